rs_pool: RTL

//   Parametrised reservation-station pool for the out-of-order core; replaces the fixed 2-entry stations inside adder/loader.

---
 rtl/rs_pool.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/rs_pool.sv
// rs_pool: reservation-station pool that snoops NUM_CDB result buses and issues ready ops to one function unit.
// Define RS_AGE_ORDER_EN for oldest-ready selection through an age matrix; the default selects the lowest-index ready entry.
module rs_pool #(
    parameter int NUM_RS   = 4,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 4,
    parameter int TAG_BASE = 0,
    parameter int NUM_CDB  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         alloc_valid,
    output logic                         alloc_ready,
    input  logic [3:0]                   alloc_op,
    input  logic [3:0]                   alloc_dst,
    input  logic [DATA_W-1:0]            alloc_v0,
    input  logic [DATA_W-1:0]            alloc_v1,
    input  logic                         alloc_rdy0,
    input  logic                         alloc_rdy1,
    input  logic [TAG_W-1:0]             alloc_src0,
    input  logic [TAG_W-1:0]             alloc_src1,
    output logic [TAG_W-1:0]             alloc_tag,
    output logic [$clog2(NUM_RS+1)-1:0]  filled,
    input  logic [NUM_CDB-1:0]           cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]     cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]    cdb_data,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [3:0]                   issue_op,
    output logic [3:0]                   issue_dst,
    output logic [TAG_W-1:0]             issue_tag,
    output logic [DATA_W-1:0]            issue_v0,
    output logic [DATA_W-1:0]            issue_v1
);
    localparam int IW = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;
    localparam int CW = $clog2(NUM_RS + 1);
    localparam logic [TAG_W-1:0] NO_SRC = '1;

    typedef struct packed {
        logic              busy;
        logic [3:0]        op;
        logic [3:0]        dst;
        logic              rdy0;
        logic              rdy1;
        logic [TAG_W-1:0]  src0;
        logic [TAG_W-1:0]  src1;
        logic [DATA_W-1:0] v0;
        logic [DATA_W-1:0] v1;
    } ent_t;

    ent_t              ent_q [NUM_RS];
    ent_t              ent_d [NUM_RS];
    logic              hold_q, hold_d;
    logic [IW-1:0]     hold_idx_q, sel_idx, pick, free_idx;
    logic [NUM_RS-1:0] cand;
    logic [CW-1:0]     busy_cnt;
    logic              alloc_fire, issue_fire;

    // {hit, data}: lowest-numbered matching bus wins; the all-ones tag never matches
    function automatic logic [DATA_W:0] snoop(input logic [TAG_W-1:0] src);
        snoop = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--)
            if (cdb_valid[k] && src != NO_SRC && cdb_tag[k*TAG_W +: TAG_W] == src)
                snoop = {1'b1, cdb_data[k*DATA_W +: DATA_W]};
    endfunction

    always_comb begin
        free_idx = '0;
        busy_cnt = '0;
        cand     = '0;
        for (int i = NUM_RS - 1; i >= 0; i--) begin
            if (!ent_q[i].busy) free_idx = IW'(i);
            busy_cnt = busy_cnt + CW'(ent_q[i].busy);
            cand[i]  = ent_q[i].busy && ent_q[i].rdy0 && ent_q[i].rdy1;
        end
    end

`ifdef RS_AGE_ORDER_EN
    localparam int AW = (NUM_RS > 1) ? NUM_RS * (NUM_RS - 1) / 2 : 1;
    // bit pidx(i,j), i<j, is set when entry i was allocated before entry j
    logic [AW-1:0]     age_q, age_d;
    logic [NUM_RS-1:0] win;

    function automatic int pidx(input int i, input int j);
        return i * NUM_RS - i * (i + 1) / 2 + j - i - 1;
    endfunction

    always_comb begin
        win   = cand;
        pick  = '0;
        age_d = age_q;
        for (int i = 0; i < NUM_RS; i++)
            for (int j = i + 1; j < NUM_RS; j++) begin
                if (cand[i] && cand[j]) begin
                    if (age_q[pidx(i, j)]) win[j] = 1'b0;
                    else win[i] = 1'b0;
                end
                if (alloc_fire && free_idx == IW'(i)) age_d[pidx(i, j)] = 1'b0;
                else if (alloc_fire && free_idx == IW'(j)) age_d[pidx(i, j)] = 1'b1;
            end
        for (int i = NUM_RS - 1; i >= 0; i--)
            if (win[i]) pick = IW'(i);
        if (flush) age_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) age_q <= '0;
        else age_q <= age_d;
`else
    always_comb begin
        pick = '0;
        for (int i = NUM_RS - 1; i >= 0; i--)
            if (cand[i]) pick = IW'(i);
    end
`endif

    assign issue_valid = hold_q || (|cand);
    assign sel_idx     = hold_q ? hold_idx_q : pick;
    assign alloc_ready = busy_cnt != CW'(NUM_RS);
    assign alloc_fire  = alloc_valid && alloc_ready && !flush;
    assign issue_fire  = issue_valid && issue_ready && !flush;
    assign hold_d      = !flush && issue_valid && !issue_ready;
    assign filled      = busy_cnt;
    assign alloc_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
    assign issue_tag   = issue_valid ? TAG_W'(TAG_BASE) + TAG_W'(sel_idx) : '0;
    assign issue_op    = issue_valid ? ent_q[sel_idx].op : '0;
    assign issue_dst   = issue_valid ? ent_q[sel_idx].dst : '0;
    assign issue_v0    = issue_valid ? ent_q[sel_idx].v0 : '0;
    assign issue_v1    = issue_valid ? ent_q[sel_idx].v1 : '0;

    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < NUM_RS; i++) begin
            if (ent_q[i].busy && !ent_q[i].rdy0) {ent_d[i].rdy0, ent_d[i].v0} = snoop(ent_q[i].src0);
            if (ent_q[i].busy && !ent_q[i].rdy1) {ent_d[i].rdy1, ent_d[i].v1} = snoop(ent_q[i].src1);
            if (flush || (issue_fire && sel_idx == IW'(i))) ent_d[i].busy = 1'b0;
        end
        if (alloc_fire) begin
            ent_d[free_idx].busy = 1'b1;
            ent_d[free_idx].op   = alloc_op;
            ent_d[free_idx].dst  = alloc_dst;
            ent_d[free_idx].src0 = alloc_src0;
            ent_d[free_idx].src1 = alloc_src1;
            {ent_d[free_idx].rdy0, ent_d[free_idx].v0} = alloc_rdy0 ? {1'b1, alloc_v0} : snoop(alloc_src0);
            {ent_d[free_idx].rdy1, ent_d[free_idx].v1} = alloc_rdy1 ? {1'b1, alloc_v1} : snoop(alloc_src1);
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < NUM_RS; i++) ent_q[i] <= '0;
            hold_q     <= 1'b0;
            hold_idx_q <= '0;
        end else begin
            ent_q      <= ent_d;
            hold_q     <= hold_d;
            hold_idx_q <= sel_idx;
        end
endmodule
